// File: rtl/user_dma_pkg.sv
// Shared register map, control/status bit positions and manager FSM encodings
// for the user-domain word-copy DMA.
package user_dma_pkg;

   localparam logic [2:0] REG_SRC    = 3'd0;
   localparam logic [2:0] REG_DST    = 3'd1;
   localparam logic [2:0] REG_LEN    = 3'd2;
   localparam logic [2:0] REG_CTRL   = 3'd3;
   localparam logic [2:0] REG_STATUS = 3'd4;

   localparam int CTRL_START    = 0;
   localparam int CTRL_IRQ_EN   = 1;
   localparam int STATUS_BUSY   = 0;
   localparam int STATUS_DONE   = 1;
   localparam int STATUS_ERR    = 2;

   typedef logic [2:0] dma_state_e;

   localparam dma_state_e ST_IDLE    = 3'd0;
   localparam dma_state_e ST_RD_REQ  = 3'd1;
   localparam dma_state_e ST_RD_WAIT = 3'd2;
   localparam dma_state_e ST_WR_REQ  = 3'd3;
   localparam dma_state_e ST_WR_WAIT = 3'd4;
   localparam dma_state_e ST_FIN     = 3'd5;
   localparam dma_state_e ST_ABORT   = 3'd6;

endpackage

// File: rtl/user_obi_dma_regs.sv
// OBI subordinate register file: always grants, answers one cycle after each request;
// exposes config, a START pulse and the sticky DONE/ERR status with the registered IRQ.
module user_obi_dma_regs
   import user_dma_pkg::*;
#(
   parameter int unsigned IdWidth     = 1,
   parameter int unsigned MaxLenWidth = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   sbr_req_i,
   output logic                   sbr_gnt_o,
   input  logic [31:0]            sbr_addr_i,
   input  logic                   sbr_we_i,
   input  logic [3:0]             sbr_be_i,
   input  logic [31:0]            sbr_wdata_i,
   input  logic [IdWidth-1:0]     sbr_aid_i,
   output logic                   sbr_rvalid_o,
   output logic [31:0]            sbr_rdata_o,
   output logic [IdWidth-1:0]     sbr_rid_o,
   output logic                   sbr_err_o,
   input  logic                   busy_i,
   input  logic                   done_set_i,
   input  logic                   err_set_i,
   output logic                   start_o,
   output logic [31:0]            src_o,
   output logic [31:0]            dst_o,
   output logic [MaxLenWidth-1:0] len_o,
   output logic                   irq_o
);

   logic [31:0]            src_q, src_d, dst_q, dst_d;
   logic [MaxLenWidth-1:0] len_q, len_d;
   logic                   irq_en_q, irq_en_d, done_q, done_d, err_q, err_d, irq_q, irq_d;
   logic                   rvalid_q, rvalid_d, rerr_q, rerr_d;
   logic [31:0]            rdata_q, rdata_d;
   logic [IdWidth-1:0]     rid_q, rid_d;
   logic [2:0]             offset;
   logic                   mapped, wr, cfg_wr;
   logic                   unused_bits;

   assign offset      = sbr_addr_i[4:2];
   assign mapped      = (offset <= REG_STATUS);
   assign wr          = sbr_req_i && sbr_we_i && mapped;
   assign cfg_wr      = wr && !busy_i;
   assign unused_bits = ^{sbr_be_i, sbr_addr_i[31:5], sbr_addr_i[1:0]};

   always_comb begin
      src_d    = src_q;
      dst_d    = dst_q;
      len_d    = len_q;
      irq_en_d = irq_en_q;
      done_d   = done_q;
      err_d    = err_q;
      if (cfg_wr) begin
         case (offset)
            REG_SRC:  src_d    = {sbr_wdata_i[31:2], 2'b00};
            REG_DST:  dst_d    = {sbr_wdata_i[31:2], 2'b00};
            REG_LEN:  len_d    = {sbr_wdata_i[MaxLenWidth-1:2], 2'b00};
            REG_CTRL: irq_en_d = sbr_wdata_i[CTRL_IRQ_EN];
            default:  ;
         endcase
      end
      if (wr && offset == REG_STATUS) begin
         if (sbr_wdata_i[STATUS_DONE]) done_d = 1'b0;
         if (sbr_wdata_i[STATUS_ERR])  err_d  = 1'b0;
      end
      // Hardware set is applied last so it beats a same-cycle W1C.
      if (done_set_i) done_d = 1'b1;
      if (err_set_i)  err_d  = 1'b1;
      irq_d = irq_en_d && (done_d || err_d);

      rdata_d = '0;
      if (sbr_req_i && !sbr_we_i) begin
         case (offset)
            REG_SRC:    rdata_d = src_q;
            REG_DST:    rdata_d = dst_q;
            REG_LEN:    rdata_d = 32'(len_q);
            REG_CTRL:   rdata_d[CTRL_IRQ_EN] = irq_en_q;
            REG_STATUS: begin
               rdata_d[STATUS_BUSY] = busy_i;
               rdata_d[STATUS_DONE] = done_q;
               rdata_d[STATUS_ERR]  = err_q;
            end
            default:    ;
         endcase
      end
      rvalid_d = sbr_req_i;
      rerr_d   = sbr_req_i && !mapped;
      rid_d    = sbr_req_i ? sbr_aid_i : '0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         src_q    <= '0;
         dst_q    <= '0;
         len_q    <= '0;
         irq_en_q <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         irq_q    <= 1'b0;
         rvalid_q <= 1'b0;
         rerr_q   <= 1'b0;
         rdata_q  <= '0;
         rid_q    <= '0;
      end else begin
         src_q    <= src_d;
         dst_q    <= dst_d;
         len_q    <= len_d;
         irq_en_q <= irq_en_d;
         done_q   <= done_d;
         err_q    <= err_d;
         irq_q    <= irq_d;
         rvalid_q <= rvalid_d;
         rerr_q   <= rerr_d;
         rdata_q  <= rdata_d;
         rid_q    <= rid_d;
      end
   end

   assign sbr_gnt_o    = 1'b1;
   assign sbr_rvalid_o = rvalid_q;
   assign sbr_rdata_o  = rdata_q;
   assign sbr_rid_o    = rid_q;
   assign sbr_err_o    = rerr_q;
   assign start_o      = cfg_wr && (offset == REG_CTRL) && sbr_wdata_i[CTRL_START];
   assign src_o        = src_q;
   assign dst_o        = dst_q;
   assign len_o        = len_q;
   assign irq_o        = irq_q;

endmodule

// File: rtl/user_obi_dma.sv
// Word-copy DMA: one OBI read then one OBI write per word, single transaction outstanding,
// 4 cycles per word on a zero-wait bus; requests are held stable until granted.
module user_obi_dma
   import user_dma_pkg::*;
#(
   parameter int unsigned IdWidth     = 1,
   parameter int unsigned MaxLenWidth = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               sbr_req_i,
   output logic               sbr_gnt_o,
   input  logic [31:0]        sbr_addr_i,
   input  logic               sbr_we_i,
   input  logic [3:0]         sbr_be_i,
   input  logic [31:0]        sbr_wdata_i,
   input  logic [IdWidth-1:0] sbr_aid_i,
   output logic               sbr_rvalid_o,
   output logic [31:0]        sbr_rdata_o,
   output logic [IdWidth-1:0] sbr_rid_o,
   output logic               sbr_err_o,
   output logic               mgr_req_o,
   input  logic               mgr_gnt_i,
   output logic [31:0]        mgr_addr_o,
   output logic               mgr_we_o,
   output logic [3:0]         mgr_be_o,
   output logic [31:0]        mgr_wdata_o,
   input  logic               mgr_rvalid_i,
   input  logic [31:0]        mgr_rdata_i,
   input  logic               mgr_err_i,
   output logic               irq_o
);

   dma_state_e             state_q, state_d;
   logic [31:0]            cur_src_q, cur_src_d, cur_dst_q, cur_dst_d, buf_q, buf_d;
   logic [MaxLenWidth-1:0] rem_q, rem_d, rem_dec, len_cfg;
   logic [31:0]            src_cfg, dst_cfg;
   logic                   start, busy, done_set, err_set;

   user_obi_dma_regs #(
      .IdWidth     (IdWidth),
      .MaxLenWidth (MaxLenWidth)
   ) i_regs (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .sbr_req_i    (sbr_req_i),
      .sbr_gnt_o    (sbr_gnt_o),
      .sbr_addr_i   (sbr_addr_i),
      .sbr_we_i     (sbr_we_i),
      .sbr_be_i     (sbr_be_i),
      .sbr_wdata_i  (sbr_wdata_i),
      .sbr_aid_i    (sbr_aid_i),
      .sbr_rvalid_o (sbr_rvalid_o),
      .sbr_rdata_o  (sbr_rdata_o),
      .sbr_rid_o    (sbr_rid_o),
      .sbr_err_o    (sbr_err_o),
      .busy_i       (busy),
      .done_set_i   (done_set),
      .err_set_i    (err_set),
      .start_o      (start),
      .src_o        (src_cfg),
      .dst_o        (dst_cfg),
      .len_o        (len_cfg),
      .irq_o        (irq_o)
   );

   assign busy    = (state_q == ST_RD_REQ) || (state_q == ST_RD_WAIT) ||
                    (state_q == ST_WR_REQ) || (state_q == ST_WR_WAIT);
   assign rem_dec = rem_q - MaxLenWidth'(4);

   always_comb begin
      state_d   = state_q;
      cur_src_d = cur_src_q;
      cur_dst_d = cur_dst_q;
      rem_d     = rem_q;
      buf_d     = buf_q;
      done_set  = 1'b0;
      err_set   = 1'b0;
      case (state_q)
         // FIN/ABORT behave as IDLE so a START arriving right after completion is not lost;
         // DONE/ERR were already set on the edge that entered them.
         ST_IDLE, ST_FIN, ST_ABORT: begin
            state_d = ST_IDLE;
            if (start) begin
               if (len_cfg == '0) begin
                  done_set = 1'b1;
               end else begin
                  cur_src_d = src_cfg;
                  cur_dst_d = dst_cfg;
                  rem_d     = len_cfg;
                  state_d   = ST_RD_REQ;
               end
            end
         end
         ST_RD_REQ: if (mgr_gnt_i) state_d = ST_RD_WAIT;
         ST_RD_WAIT: begin
            if (mgr_rvalid_i) begin
               buf_d = mgr_rdata_i;
               if (mgr_err_i) begin
                  err_set = 1'b1;
                  state_d = ST_ABORT;
               end else begin
                  state_d = ST_WR_REQ;
               end
            end
         end
         ST_WR_REQ: if (mgr_gnt_i) state_d = ST_WR_WAIT;
         ST_WR_WAIT: begin
            if (mgr_rvalid_i) begin
               if (mgr_err_i) begin
                  err_set = 1'b1;
                  state_d = ST_ABORT;
               end else begin
                  cur_src_d = cur_src_q + 32'd4;
                  cur_dst_d = cur_dst_q + 32'd4;
                  rem_d     = rem_dec;
                  if (rem_dec == '0) begin
                     done_set = 1'b1;
                     state_d  = ST_FIN;
                  end else begin
                     state_d  = ST_RD_REQ;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         cur_src_q <= '0;
         cur_dst_q <= '0;
         rem_q     <= '0;
         buf_q     <= '0;
      end else begin
         state_q   <= state_d;
         cur_src_q <= cur_src_d;
         cur_dst_q <= cur_dst_d;
         rem_q     <= rem_d;
         buf_q     <= buf_d;
      end
   end

   assign mgr_req_o   = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
   assign mgr_we_o    = (state_q == ST_WR_REQ);
   assign mgr_addr_o  = (state_q == ST_RD_REQ) ? cur_src_q :
                        (state_q == ST_WR_REQ) ? cur_dst_q : 32'd0;
   assign mgr_be_o    = 4'hF;
   assign mgr_wdata_o = buf_q;

endmodule

// File: tb/tb_user_obi_dma.sv
// Directed bench for user_obi_dma with an OBI memory model on the manager port
// that supports random grant stalls, error injection and response muting.
module tb_user_obi_dma;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        sbr_req_i, sbr_gnt_o, sbr_we_i, sbr_rvalid_o, sbr_err_o;
   logic [31:0] sbr_addr_i, sbr_wdata_i, sbr_rdata_o;
   logic [3:0]  sbr_be_i, mgr_be_o;
   logic        sbr_aid_i, sbr_rid_o;
   logic        mgr_req_o, mgr_gnt_i, mgr_we_o, mgr_rvalid_i, mgr_err_i, irq_o;
   logic [31:0] mgr_addr_o, mgr_wdata_o, mgr_rdata_i;

   always #5 clk = ~clk;

   user_obi_dma #(.IdWidth(1), .MaxLenWidth(16)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .sbr_req_i(sbr_req_i), .sbr_gnt_o(sbr_gnt_o), .sbr_addr_i(sbr_addr_i),
      .sbr_we_i(sbr_we_i), .sbr_be_i(sbr_be_i), .sbr_wdata_i(sbr_wdata_i),
      .sbr_aid_i(sbr_aid_i), .sbr_rvalid_o(sbr_rvalid_o), .sbr_rdata_o(sbr_rdata_o),
      .sbr_rid_o(sbr_rid_o), .sbr_err_o(sbr_err_o),
      .mgr_req_o(mgr_req_o), .mgr_gnt_i(mgr_gnt_i), .mgr_addr_o(mgr_addr_o),
      .mgr_we_o(mgr_we_o), .mgr_be_o(mgr_be_o), .mgr_wdata_o(mgr_wdata_o),
      .mgr_rvalid_i(mgr_rvalid_i), .mgr_rdata_i(mgr_rdata_i), .mgr_err_i(mgr_err_i),
      .irq_o(irq_o)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- manager-side memory model ----------------
   logic [31:0] mem [0:1023];
   logic [31:0] rd_log[$];
   logic [31:0] wr_log[$];
   int          rd_cnt = 0, wr_cnt = 0, err_at = 0, gnt_max = 0, wait_cnt = 0, stall_bad = 0;
   logic        pend = 1'b0, pend_err = 1'b0, mute = 1'b0;
   logic [31:0] pend_rdata = '0;
   logic        hold_vld = 1'b0, hold_we = 1'b0;
   logic [31:0] hold_addr = '0, hold_wdata = '0;

   initial for (int i = 0; i < 1024; i++) mem[i] = {16'hC0DE, 16'(i)};

   always @(negedge clk) begin
      mgr_rvalid_i = 1'b0;
      mgr_err_i    = 1'b0;
      mgr_rdata_i  = '0;
      mgr_gnt_i    = 1'b0;
      if (pend && !mute) begin
         mgr_rvalid_i = 1'b1;
         mgr_rdata_i  = pend_rdata;
         mgr_err_i    = pend_err;
         pend         = 1'b0;
      end
      if (hold_vld && (!mgr_req_o || mgr_addr_o != hold_addr || mgr_we_o != hold_we ||
                       mgr_wdata_o != hold_wdata))
         stall_bad++;
      hold_vld = 1'b0;
      if (mgr_req_o) begin
         if (wait_cnt > 0) begin
            wait_cnt--;
            hold_vld   = 1'b1;
            hold_addr  = mgr_addr_o;
            hold_we    = mgr_we_o;
            hold_wdata = mgr_wdata_o;
         end else begin
            mgr_gnt_i = 1'b1;
            wait_cnt  = int'($urandom_range(gnt_max, 0));
            if (mgr_we_o) begin
               mem[mgr_addr_o[11:2]] = mgr_wdata_o;
               wr_cnt++;
               wr_log.push_back(mgr_addr_o);
               pend_rdata = '0;
               pend_err   = 1'b0;
            end else begin
               rd_cnt++;
               rd_log.push_back(mgr_addr_o);
               pend_rdata = mem[mgr_addr_o[11:2]];
               pend_err   = (rd_cnt == err_at);
            end
            pend = 1'b1;
         end
      end
   end

   // ---------------- subordinate-side access tasks ----------------
   task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic aid, output logic rv, output logic [31:0] rdata,
                      output logic err, output logic rid);
      sbr_req_i   = 1'b1;
      sbr_we_i    = we;
      sbr_addr_i  = addr;
      sbr_wdata_i = wdata;
      sbr_aid_i   = aid;
      sbr_be_i    = 4'h1;
      @(negedge clk);
      rv    = sbr_rvalid_o;
      rdata = sbr_rdata_o;
      err   = sbr_err_o;
      rid   = sbr_rid_o;
      sbr_req_i = 1'b0;
      sbr_we_i  = 1'b0;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      logic rv, e, id;
      logic [31:0] d;
      bus(1'b1, addr, data, 1'b0, rv, d, e, id);
   endtask

   task automatic rd(input logic [31:0] addr, output logic [31:0] data);
      logic rv, e, id;
      bus(1'b0, addr, 32'd0, 1'b0, rv, data, e, id);
   endtask

   task automatic wait_idle(input int max_polls);
      logic [31:0] st;
      st = 32'd1;
      for (int i = 0; i < max_polls && st[0]; i++) rd(32'h10, st);
      chk("idle_timeout", {31'd0, st[0]}, 32'd0);
   endtask

   // ---------------- directed sequence ----------------
   logic        rv, e, id;
   logic [31:0] d;
   int          w0, r0;

   initial begin
      rst_i = 1'b1; sbr_req_i = 1'b0; sbr_we_i = 1'b0; sbr_addr_i = '0;
      sbr_wdata_i = '0; sbr_aid_i = 1'b0; sbr_be_i = '0;
      repeat (3) @(negedge clk);
      chk("rst_mgr_req", {31'd0, mgr_req_o}, 32'd0);
      chk("rst_rvalid", {31'd0, sbr_rvalid_o}, 32'd0);
      chk("rst_irq", {31'd0, irq_o}, 32'd0);
      rst_i = 1'b0;
      @(negedge clk);
      chk("idle_rvalid", {31'd0, sbr_rvalid_o}, 32'd0);

      // register access
      bus(1'b1, 32'h0, 32'h1003, 1'b1, rv, d, e, id);
      chk("wr_rvalid", {31'd0, rv}, 32'd1);
      chk("wr_rid", {31'd0, id}, 32'd1);
      chk("wr_err", {31'd0, e}, 32'd0);
      bus(1'b0, 32'h0, 32'h0, 1'b1, rv, d, e, id);
      chk("src_read", d, 32'h1000);
      chk("rd_rid", {31'd0, id}, 32'd1);
      bus(1'b0, 32'h14, 32'h0, 1'b0, rv, d, e, id);
      chk("unmapped_err", {31'd0, e}, 32'd1);
      chk("unmapped_rdata", d, 32'd0);
      chk("unmapped_rid", {31'd0, id}, 32'd0);
      bus(1'b1, 32'h18, 32'hFFFF_FFFF, 1'b0, rv, d, e, id);
      rd(32'h0, d);
      chk("unmapped_nochange", d, 32'h1000);

      // basic copy, zero-wait bus
      wr(32'h0, 32'h100); wr(32'h4, 32'h200); wr(32'h8, 32'd12); wr(32'hC, 32'h2);
      wr(32'hC, 32'h3);
      repeat (11) @(negedge clk);
      rd(32'h10, d);
      chk("busy_cycle11", d, 32'h1);
      rd(32'h10, d);
      chk("done_cycle12", d, 32'h2);
      chk("irq_set", {31'd0, irq_o}, 32'd1);
      chk("rd_count", rd_log.size(), 32'd3);
      for (int k = 0; k < 3; k++) begin
         chk("rd_addr", rd_log[k], 32'h100 + 32'(4 * k));
         chk("wr_addr", wr_log[k], 32'h200 + 32'(4 * k));
         chk("copy_data", mem[32'h80 + k], {16'hC0DE, 16'h40 + 16'(k)});
      end
      wr(32'h10, 32'h2);
      chk("irq_clear", {31'd0, irq_o}, 32'd0);
      rd(32'h10, d);
      chk("status_clear", d, 32'd0);

      // grant stalls
      gnt_max = 5;
      wr(32'h0, 32'h300); wr(32'h4, 32'h400); wr(32'h8, 32'd20); wr(32'hC, 32'h3);
      wait_idle(400);
      chk("stall_stable", 32'(stall_bad), 32'd0);
      rd(32'h10, d);
      chk("stall_done", d, 32'h2);
      for (int k = 0; k < 5; k++)
         chk("stall_data", mem[32'h100 + k], {16'hC0DE, 16'hC0 + 16'(k)});
      wr(32'h10, 32'h2);
      gnt_max = 0;
      repeat (8) @(negedge clk);

      // error on second read
      w0 = wr_cnt;
      err_at = rd_cnt + 2;
      wr(32'h0, 32'h100); wr(32'h4, 32'h800); wr(32'h8, 32'd16); wr(32'hC, 32'h1);
      wait_idle(100);
      chk("abort_writes", 32'(wr_cnt - w0), 32'd1);
      rd(32'h10, d);
      chk("abort_status", d, 32'h4);
      err_at = 0;
      wr(32'h10, 32'h4);
      rd(32'h10, d);
      chk("err_w1c", d, 32'd0);

      // LEN == 0 start
      r0 = rd_cnt; w0 = wr_cnt;
      wr(32'h8, 32'd0);
      wr(32'hC, 32'h1);
      chk("len0_noreq", {31'd0, mgr_req_o}, 32'd0);
      rd(32'h10, d);
      chk("len0_done", d, 32'h2);
      chk("len0_traffic", 32'((rd_cnt - r0) + (wr_cnt - w0)), 32'd0);
      wr(32'h10, 32'h2);

      // config writes and START dropped while busy
      w0 = wr_cnt;
      wr(32'h0, 32'h500); wr(32'h4, 32'h600); wr(32'h8, 32'd8); wr(32'hC, 32'h1);
      bus(1'b1, 32'h0, 32'h900, 1'b0, rv, d, e, id);
      chk("busy_wr_err", {31'd0, e}, 32'd0);
      wr(32'hC, 32'h1);
      rd(32'h0, d);
      chk("busy_src_kept", d, 32'h500);
      wait_idle(100);
      chk("busy_writes", 32'(wr_cnt - w0), 32'd2);
      chk("busy_last_addr", wr_log[wr_log.size() - 1], 32'h604);
      chk("busy_data0", mem[32'h180], 32'hC0DE_0140);
      chk("busy_data1", mem[32'h181], 32'hC0DE_0141);
      wr(32'h10, 32'h2);

      // reset while in WR_WAIT, then a stale response
      w0 = wr_cnt;
      wr(32'h0, 32'h100); wr(32'h4, 32'h700); wr(32'h8, 32'd12); wr(32'hC, 32'h3);
      repeat (2) @(negedge clk);
      #1 mute = 1'b1;
      @(negedge clk);
      chk("wr_wait_noreq", {31'd0, mgr_req_o}, 32'd0);
      rst_i = 1'b1;
      #1 mute = 1'b0;
      @(negedge clk);
      rst_i = 1'b0;
      chk("rr_mgr_req", {31'd0, mgr_req_o}, 32'd0);
      chk("rr_mgr_we", {31'd0, mgr_we_o}, 32'd0);
      chk("rr_mgr_addr", mgr_addr_o, 32'd0);
      chk("rr_mgr_wdata", mgr_wdata_o, 32'd0);
      chk("rr_sbr_rvalid", {31'd0, sbr_rvalid_o}, 32'd0);
      chk("rr_sbr_err", {31'd0, sbr_err_o}, 32'd0);
      chk("rr_sbr_rdata", sbr_rdata_o, 32'd0);
      chk("rr_sbr_rid", {31'd0, sbr_rid_o}, 32'd0);
      chk("rr_irq", {31'd0, irq_o}, 32'd0);
      @(negedge clk);
      chk("stale_ignored", {31'd0, mgr_req_o}, 32'd0);
      rd(32'h10, d);
      chk("rr_status", d, 32'd0);
      rd(32'h0, d);
      chk("rr_src", d, 32'd0);
      chk("rr_writes", 32'(wr_cnt - w0), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
